// File: rtl/serial_word_feeder_if.sv
// Word-in / bit-out bundle between a parallel word source, the feeder and the detector input.
interface serial_word_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_done;

    modport master (
        output din, din_valid,
        input  din_ready, dout, dout_valid, busy, frame_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, dout_valid, busy, frame_done
    );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: WIDTH-bit words in over valid/ready, one registered bit per clock out.
// A new word can be taken while the last bit of the current one is on dout, giving gap-free streams.
module serial_word_feeder #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic               clk,
    input logic               rst,
    serial_word_feeder_if.slave bus
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        SHIFT = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             dout_q, dout_nxt;
    logic             dv_q, dv_nxt;
    logic             busy_q, busy_nxt;
    logic             fd_q, fd_nxt;
    logic             ready;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Ready is also open on the last bit so the next word lands without an idle cycle.
    assign ready  = !rst && (state == IDLE || (state == SHIFT && cnt == '0));
    assign accept = bus.din_valid && ready;

    assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    always_comb begin
        state_nxt = IDLE;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        dout_nxt  = IDLE_LEVEL;
        dv_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        fd_nxt    = 1'b0;
        if (accept) begin
            state_nxt = SHIFT;
            sreg_nxt  = bus.din;
            cnt_nxt   = CNT_LAST;
            dout_nxt  = first_bit(bus.din);
            dv_nxt    = 1'b1;
            busy_nxt  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        state_nxt = SHIFT;
                        sreg_nxt  = shifted;
                        cnt_nxt   = cnt - CNT_ONE;
                        dout_nxt  = first_bit(shifted);
                        dv_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                        fd_nxt    = (cnt == CNT_ONE);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            dout_q <= IDLE_LEVEL;
            dv_q   <= 1'b0;
            busy_q <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            cnt    <= cnt_nxt;
            dout_q <= dout_nxt;
            dv_q   <= dv_nxt;
            busy_q <= busy_nxt;
            fd_q   <= fd_nxt;
        end
    end

    assign bus.din_ready  = ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: MSB-first, LSB-first and IDLE_LEVEL=1 instances on one clock.
module tb_serial_word_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_word_feeder_if #(.WIDTH(8)) m_if ();
    serial_word_feeder_if #(.WIDTH(8)) l_if ();
    serial_word_feeder_if #(.WIDTH(8)) i_if ();

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rst(rst), .bus(m_if)
    );
    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .bus(l_if)
    );
    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_idle (
        .clk(clk), .rst(rst), .bus(i_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // The IDLE_LEVEL=1 instance never sees a word: it must sit at 1 with ready tracking !rst.
    task automatic check_idle_dut(input string tag);
        check({tag, "_idle_dout"},  32'(i_if.dout), 32'd1);
        check({tag, "_idle_dv"},    32'(i_if.dout_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(i_if.din_ready), 32'(!rst));
    endtask

    // w0 accepted at edge 0; when 'second', din_valid with w1 is held from cycle start1 to cycle 8.
    task automatic run_seq(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input bit second, input int start1);
        int   last;
        logic eb, ev, ef, er;
        last = second ? 17 : 9;
        @(negedge clk);
        m_if.din       = w0;
        m_if.din_valid = 1'b1;
        #1;
        check($sformatf("%s_ready_c0", tag), 32'(m_if.din_ready), 32'd1);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            ev = (c <= 8) || (second && c <= 16);
            ef = (c == 8) || (second && c == 16);
            if (c <= 8)      eb = w0[8 - c];
            else if (ev)     eb = w1[16 - c];
            else             eb = 1'b0;
            if (c <= 7)                 er = 1'b0;
            else if (c == 8)            er = 1'b1;
            else if (second && c <= 15) er = 1'b0;
            else                        er = 1'b1;
            check($sformatf("%s_dout_c%0d", tag, c), 32'(m_if.dout), 32'(eb));
            check($sformatf("%s_dv_c%0d", tag, c),   32'(m_if.dout_valid), 32'(ev));
            check($sformatf("%s_busy_c%0d", tag, c), 32'(m_if.busy), 32'(ev));
            check($sformatf("%s_fd_c%0d", tag, c),   32'(m_if.frame_done), 32'(ef));
            check_idle_dut($sformatf("%s_c%0d", tag, c));
            m_if.din       = w1;
            m_if.din_valid = second && (c >= start1) && (c <= 8);
            #1;
            check($sformatf("%s_ready_c%0d", tag, c), 32'(m_if.din_ready), 32'(er));
        end
    endtask

    initial begin
        logic [7:0] lw;
        logic [7:0] rw;
        logic [7:0] fw;
        m_if.din = '0; m_if.din_valid = 1'b0;
        l_if.din = '0; l_if.din_valid = 1'b0;
        i_if.din = '0; i_if.din_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_dout",  32'(m_if.dout), 32'd0);
        check("rst_dv",    32'(m_if.dout_valid), 32'd0);
        check("rst_busy",  32'(m_if.busy), 32'd0);
        check("rst_fd",    32'(m_if.frame_done), 32'd0);
        check("rst_ready", 32'(m_if.din_ready), 32'd0);
        check("rst_lsb_ready", 32'(l_if.din_ready), 32'd0);
        check_idle_dut("rst");
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(m_if.din_ready), 32'd1);
        check_idle_dut("post_rst");

        run_seq("single", 8'hB6, 8'h00, 1'b0, 99);
        run_seq("b2b",    8'hB6, 8'h6D, 1'b1, 1);
        run_seq("hold",   8'hB6, 8'hFF, 1'b1, 2);

        // LSB-first: 8'h0D goes out as 1,0,1,1,0,0,0,0
        lw = 8'h0D;
        @(negedge clk);
        l_if.din       = lw;
        l_if.din_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            l_if.din_valid = 1'b0;
            check($sformatf("lsb_dout_c%0d", c), 32'(l_if.dout), (c <= 8) ? 32'(lw[c - 1]) : 32'd0);
            check($sformatf("lsb_dv_c%0d", c),   32'(l_if.dout_valid), 32'(c <= 8));
            check($sformatf("lsb_fd_c%0d", c),   32'(l_if.frame_done), 32'(c == 8));
        end

        // Reset asserted at the edge ending cycle 4, then 8'h0F offered straight after.
        rw = 8'hB6;
        fw = 8'h0F;
        @(negedge clk);
        m_if.din       = rw;
        m_if.din_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            m_if.din_valid = 1'b0;
            check($sformatf("mid_dout_c%0d", c), 32'(m_if.dout), 32'(rw[8 - c]));
        end
        rst = 1'b1;
        #1;
        check("mid_ready_in_rst", 32'(m_if.din_ready), 32'd0);
        check_idle_dut("mid_rst");
        @(negedge clk);
        check("mid_abort_dout", 32'(m_if.dout), 32'd0);
        check("mid_abort_dv",   32'(m_if.dout_valid), 32'd0);
        check("mid_abort_busy", 32'(m_if.busy), 32'd0);
        check("mid_abort_fd",   32'(m_if.frame_done), 32'd0);
        rst            = 1'b0;
        m_if.din       = fw;
        m_if.din_valid = 1'b1;
        #1;
        check("mid_ready_after", 32'(m_if.din_ready), 32'd1);
        for (int c = 6; c <= 14; c++) begin
            @(negedge clk);
            m_if.din_valid = 1'b0;
            check($sformatf("rst_word_dout_c%0d", c), 32'(m_if.dout),
                  (c <= 13) ? 32'(fw[13 - c]) : 32'd0);
            check($sformatf("rst_word_dv_c%0d", c), 32'(m_if.dout_valid), 32'(c <= 13));
            check($sformatf("rst_word_fd_c%0d", c), 32'(m_if.frame_done), 32'(c == 13));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
